// File: rtl/program_loader.sv
// Byte-stream program loader: writes a length-prefixed program into CPU memory,
// verifies a trailing 8-bit additive checksum, and releases the CPU from reset.
module program_loader #(
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [5:0]                 load_len,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       mem_wr,
  output logic [$clog2(DEPTH)-1:0]   mem_addr,
  output logic [7:0]                 mem_din,
  output logic                       cpu_rst_n,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int AW     = $clog2(DEPTH);
  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [LEN_W-1:0]    r_cnt;
  logic [LEN_W-1:0]    r_len;
  logic [DATA_W-1:0]   r_sum;
  logic                r_mem_wr;
  logic [AW-1:0]       r_mem_addr;
  logic [DATA_W-1:0]   r_mem_din;
  logic                r_cpu_rst_n;
  logic                r_done;
  logic                r_err;

  logic                w_accept;
  logic                w_len_ok;
  logic                w_can_start;
  logic                w_last_byte;
  logic                w_chk_ok;

  // Checksum accumulates modulo 256; the carry out is intentionally dropped.
  function automatic logic [DATA_W-1:0] f_sum_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[DATA_W-1:0];
  endfunction

  assign in_ready    = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign busy        = in_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_len_ok    = (load_len != '0) && (int'(load_len) <= DEPTH);
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR);
  assign w_last_byte = ((r_cnt + 6'd1) == r_len);
  assign w_chk_ok    = (in_data == r_sum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) w_state_nxt = w_len_ok ? S_LOAD : S_ERROR;
      end
      S_LOAD: begin
        if (w_accept && w_last_byte) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_accept) w_state_nxt = w_chk_ok ? S_RUN : S_ERROR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs follow the next state so cpu_rst_n drops on the LOAD entry edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_len       <= '0;
      r_sum       <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_cpu_rst_n <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_wr    <= 1'b0;
      r_done      <= 1'b0;
      r_cpu_rst_n <= (w_state_nxt == S_RUN);
      r_err       <= (w_state_nxt == S_ERROR);
      if (w_can_start && start && w_len_ok) begin
        r_cnt <= '0;
        r_sum <= '0;
        r_len <= load_len;
      end
      if ((r_state == S_LOAD) && w_accept) begin
        r_mem_wr   <= 1'b1;
        r_mem_addr <= r_cnt[AW-1:0];
        r_mem_din  <= in_data;
        r_cnt      <= r_cnt + 6'd1;
        r_sum      <= f_sum_wrap(r_sum, in_data);
      end
      if ((r_state == S_CHECK) && w_accept && w_chk_ok) begin
        r_done <= 1'b1;
      end
    end
  end

  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign cpu_rst_n = r_cpu_rst_n;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a queue-based reference model predicts the
// memory writes and the load outcome from the byte list and the checksum rule.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] load_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_din;
  logic       cpu_rst_n;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errs   = 0;
  int done_total = 0;

  logic [4:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] prog[0:63];

  always #5 clk = ~clk;

  program_loader #(.DEPTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_len  (load_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Observed write log and done-pulse count, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_din);
    end
    if (done === 1'b1) done_total++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sum_of(input int len);
    int s;
    s = 0;
    for (int i = 0; i < len; i++) s = (s + int'(prog[i])) % 256;
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int stall_pct, output bit sent);
    bit now;
    sent = 1'b0;
    for (int t = 0; t < 400 && !sent; t++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 99) >= stall_pct);
      in_data  = in_valid ? b : 8'($urandom);
      now      = in_valid && in_ready;
      @(posedge clk);
      sent = now;
    end
    if (!sent) check_val("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_load(input int len, input logic [7:0] chk, input int stall_pct,
                          input bit poke_start);
    int  base;
    int  dbase;
    int  nw;
    bit  ok;
    bit  sent;
    ok    = (sum_of(len) == int'(chk));
    base  = wa.size();
    dbase = done_total;
    @(negedge clk);
    start    = 1'b1;
    load_len = 6'(len);
    @(negedge clk);
    start = 1'b0;
    check_val("entry_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_val("entry_busy", 32'(busy), 32'd1);
    check_val("entry_err", 32'(err), 32'd0);
    if (poke_start) begin
      start    = 1'b1;
      load_len = 6'd5;
      @(negedge clk);
      start = 1'b0;
      check_val("poke_busy", 32'(busy), 32'd1);
    end
    for (int i = 0; i < len; i++) begin
      send_byte(prog[i], stall_pct, sent);
      if (!sent) begin
        in_valid = 1'b0;
        return;
      end
    end
    send_byte(chk, stall_pct, sent);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    nw = wa.size() - base;
    check_val("wr_count", 32'(nw), 32'(len));
    for (int i = 0; i < len && i < nw; i++) begin
      check_val("wr_addr", 32'(wa[base+i]), 32'(i));
      check_val("wr_data", 32'(wd[base+i]), 32'(prog[i]));
    end
    check_val("done_pulses", 32'(done_total - dbase), ok ? 32'd1 : 32'd0);
    check_val("err", 32'(err), ok ? 32'd0 : 32'd1);
    check_val("cpu_rst_n", 32'(cpu_rst_n), ok ? 32'd1 : 32'd0);
    check_val("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic bad_start(input logic [5:0] len);
    int base;
    base = wa.size();
    @(negedge clk);
    start    = 1'b1;
    load_len = len;
    @(negedge clk);
    start = 1'b0;
    check_val("bad_err", 32'(err), 32'd1);
    check_val("bad_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_val("bad_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_val("bad_no_wr", 32'(wa.size() - base), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   sent;
    int   base;
    int   len;
    int   s;
    logic [7:0] chk;

    rst      = 1'b0;
    start    = 1'b0;
    load_len = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check_val("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_val("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    prog[0] = 8'h12; prog[1] = 8'h34; prog[2] = 8'h56;
    run_load(3, 8'h9C, 0, 1'b0);

    prog[0] = 8'hFF; prog[1] = 8'h02;
    run_load(2, 8'h01, 0, 1'b0);
    run_load(2, 8'h02, 0, 1'b0);

    bad_start(6'd0);
    bad_start(6'd33);
    prog[0] = 8'hA5;
    run_load(1, 8'hA5, 0, 1'b0);

    for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
    run_load(32, 8'(sum_of(32)), 50, 1'b0);

    prog[0] = 8'h3C;
    run_load(1, 8'h3C, 20, 1'b1);

    // Reset in the middle of a 4-byte load, right after a write strobe.
    prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33; prog[3] = 8'h44;
    @(negedge clk);
    start    = 1'b1;
    load_len = 6'd4;
    @(negedge clk);
    start = 1'b0;
    send_byte(prog[0], 0, sent);
    send_byte(prog[1], 0, sent);
    #2;
    rst = 1'b0;
    #1;
    check_val("mid_mem_wr", 32'(mem_wr), 32'd0);
    check_val("mid_mem_addr", 32'(mem_addr), 32'd0);
    check_val("mid_mem_din", 32'(mem_din), 32'd0);
    check_val("mid_done", 32'(done), 32'd0);
    check_val("mid_err", 32'(err), 32'd0);
    check_val("mid_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_val("mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst  = 1'b1;
    base = wa.size();
    for (int i = 2; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = prog[i % 4];
    end
    check_val("post_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("post_rst_no_wr", 32'(wa.size() - base), 32'd0);

    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, 32);
      for (int i = 0; i < len; i++) prog[i] = 8'($urandom);
      s   = sum_of(len);
      chk = 8'(s);
      if ($urandom_range(0, 1) == 1) chk = chk ^ 8'($urandom_range(1, 255));
      run_load(len, chk, $urandom_range(0, 60), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL provide parameter DEPTH, default 32: number of CPU memory words loadable (address width 5).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle load request.
REQ-005 SHALL have port load_len  input  6  number of program bytes, sampled with start.
REQ-006 SHALL have port in_valid  input  1  byte-stream valid.
REQ-007 SHALL have port in_data  input  8  byte-stream data.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_wr  output  1  CPU memory write strobe.
REQ-010 SHALL have port mem_addr  output  5  CPU memory write address.
REQ-011 SHALL have port mem_din  output  8  CPU memory write data.
REQ-012 SHALL have port cpu_rst_n  output  1  active-low reset to the CPU core.
REQ-013 SHALL have port busy  output  1  high in LOAD or CHECK.
REQ-014 SHALL have port done  output  1  one-cycle pulse on successful load.
REQ-015 SHALL have port err  output  1  sticky error flag.

Function
REQ-016 SHALL implement states IDLE, LOAD, CHECK, RUN, ERROR; all outputs except in_ready and busy registered.
REQ-017 Accept SHALL mean in_valid && in_ready on a rising clk edge; in_ready SHALL be high only in LOAD and CHECK.
REQ-018 IDLE/RUN/ERROR + start with 1 <= load_len <= DEPTH: next state LOAD, byte counter = 0, running sum = 0, length latched, err cleared.
REQ-019 IDLE/RUN/ERROR + start with load_len = 0 or > DEPTH: next state ERROR, err = 1, cpu_rst_n = 0.
REQ-020 start SHALL be ignored in LOAD and CHECK.
REQ-021 LOAD: byte accepted at edge N -> mem_wr = 1, mem_addr = counter, mem_din = byte during cycle after N; mem_wr low otherwise (single-cycle strobe per byte).
REQ-022 LOAD: each accept increments counter and adds byte to 8-bit sum, modulo 256 (carry discarded).
REQ-023 LOAD: accept of byte number latched length -> next state CHECK; no idle cycle inserted.
REQ-024 CHECK: next accepted byte is checksum, not written to memory (mem_wr stays 0).
REQ-025 CHECK: checksum == sum -> RUN, done = 1 for exactly one cycle, cpu_rst_n = 1 from the same cycle.
REQ-026 CHECK: checksum != sum -> ERROR, err = 1, cpu_rst_n stays 0.
REQ-027 cpu_rst_n SHALL be 0 in IDLE, LOAD, CHECK, ERROR; 1 only in RUN.
REQ-028 RUN + valid start: cpu_rst_n = 0 from the cycle LOAD is entered (CPU reset before first write).
REQ-029 in_valid while in_ready = 0: no accept, no state change, no data loss obligation.
REQ-030 Memory address SHALL never exceed latched length - 1; counter does not wrap.

Reset
REQ-031 rst low SHALL immediately force IDLE, cpu_rst_n = 0, mem_wr = 0, mem_addr = 0, mem_din = 0, done = 0, err = 0, counter = 0, sum = 0.
REQ-032 rst asserted mid-LOAD/CHECK SHALL abort the load with no further mem_wr; resumes only on a new start.
REQ-033 Exit from reset SHALL be synchronous to clk; no accept on the first edge after rst rises.

Verification
REQ-034 start, load_len=3, stream 0x12,0x34,0x56, checksum 0x9C -> writes addr0=0x12, addr1=0x34, addr2=0x56; done pulse; cpu_rst_n=1.
REQ-035 load_len=2, stream 0xFF,0x02, checksum 0x01 (sum wrap) -> success; checksum 0x02 -> err=1, cpu_rst_n=0, no done.
REQ-036 start with load_len=0 and with load_len=33 -> ERROR, err=1, no mem_wr; then valid start clears err and loads.
REQ-037 load_len=32 with in_valid toggled randomly -> exactly 32 mem_wr strobes, addresses 0..31 in order, no write on stall cycles.
REQ-038 rst pulsed low after 2 of 4 bytes -> outputs at reset values immediately; subsequent bytes with no start produce no mem_wr.
REQ-039 In RUN, new start load_len=1 -> cpu_rst_n low next cycle, busy high, start during LOAD ignored.
